// File: rtl/metrics_counter_bank.sv
// Purpose : NUM_CNT independent cycle/event counters with free-run or start/stop modes,
//           sticky overflow, wrap/saturate, and an atomic all-channel snapshot.
// Latency : cnt_o updates one cycle after a RUN cycle; snap_o/snap_valid_o one cycle after snap_i.
// Backpressure: none; every input is sampled each cycle and all outputs are registered.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cfg_en/clear/evt_mode/trig/sat  per-channel configuration bits (levels)
//   event_i, start_i, stop_i    per-channel event strobe and start/stop triggers
//   snap_i                      snapshot request for all channels
//   cnt_o, snap_o               packed live and snapshot counters (channel i at [i*W +: W])
//   snap_valid_o                one-cycle pulse when snap_o has been reloaded
//   ovf_o, running_o            sticky overflow flags, channel-in-RUN flags
module metrics_counter_bank #(
   parameter int NUM_CNT       = 4,
   parameter int COUNTER_WIDTH = 64
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NUM_CNT-1:0]                 cfg_en,
   input  logic [NUM_CNT-1:0]                 cfg_clear,
   input  logic [NUM_CNT-1:0]                 cfg_evt_mode,
   input  logic [NUM_CNT-1:0]                 cfg_trig,
   input  logic [NUM_CNT-1:0]                 cfg_sat,
   input  logic [NUM_CNT-1:0]                 event_i,
   input  logic [NUM_CNT-1:0]                 start_i,
   input  logic [NUM_CNT-1:0]                 stop_i,
   input  logic                               snap_i,
   output logic [NUM_CNT*COUNTER_WIDTH-1:0]   cnt_o,
   output logic [NUM_CNT*COUNTER_WIDTH-1:0]   snap_o,
   output logic                               snap_valid_o,
   output logic [NUM_CNT-1:0]                 ovf_o,
   output logic [NUM_CNT-1:0]                 running_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                   state_q [NUM_CNT];
   state_t                   state_d [NUM_CNT];
   // Trigger mode captured when a channel leaves IDLE, so mid-run changes to
   // cfg_trig only matter after the channel has been disabled.
   logic [NUM_CNT-1:0]       trig_mode_q, trig_mode_d;
   logic [COUNTER_WIDTH-1:0] cnt_q  [NUM_CNT];
   logic [COUNTER_WIDTH-1:0] cnt_d  [NUM_CNT];
   logic [COUNTER_WIDTH-1:0] snap_q [NUM_CNT];
   logic [COUNTER_WIDTH-1:0] snap_d [NUM_CNT];
   logic [NUM_CNT-1:0]       ovf_q, ovf_d;
   logic                     snap_valid_q, snap_valid_d;
   logic [NUM_CNT-1:0]       inc;

   // Channel FSM next state.
   always_comb begin
      trig_mode_d = trig_mode_q;
      for (int i = 0; i < NUM_CNT; i++) begin
         state_d[i] = state_q[i];
         if (!cfg_en[i]) begin
            state_d[i] = ST_IDLE;
         end else begin
            case (state_q[i])
               ST_IDLE: begin
                  trig_mode_d[i] = cfg_trig[i];
                  state_d[i]     = cfg_trig[i] ? ST_ARMED : ST_RUN;
               end
               // start wins over a simultaneous stop: stop only acts from RUN.
               ST_ARMED: if (start_i[i]) state_d[i] = ST_RUN;
               ST_RUN:   if (trig_mode_q[i] && stop_i[i]) state_d[i] = ST_DONE;
               ST_DONE:  state_d[i] = ST_DONE;
               default:  state_d[i] = ST_IDLE;
            endcase
         end
      end
   end

   // Counter, overflow and snapshot next state.
   always_comb begin
      snap_valid_d = snap_i;
      ovf_d        = ovf_q;
      inc          = '0;
      for (int i = 0; i < NUM_CNT; i++) begin
         cnt_d[i]  = cnt_q[i];
         // Snapshot takes the pre-update register value, so a same-cycle
         // clear or increment never leaks into the captured word.
         snap_d[i] = snap_i ? cnt_q[i] : snap_q[i];
         inc[i]    = (state_q[i] == ST_RUN) && (cfg_evt_mode[i] ? event_i[i] : 1'b1);
         if (cfg_clear[i]) begin
            cnt_d[i] = '0;
            ovf_d[i] = 1'b0;
         end else if (inc[i]) begin
            if (&cnt_q[i]) begin
               ovf_d[i] = 1'b1;
               cnt_d[i] = cfg_sat[i] ? cnt_q[i] : '0;
            end else begin
               cnt_d[i] = cnt_q[i] + COUNTER_WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CNT; i++) begin
            state_q[i] <= ST_IDLE;
            cnt_q[i]   <= '0;
            snap_q[i]  <= '0;
         end
         trig_mode_q  <= '0;
         ovf_q        <= '0;
         snap_valid_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CNT; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
            snap_q[i]  <= snap_d[i];
         end
         trig_mode_q  <= trig_mode_d;
         ovf_q        <= ovf_d;
         snap_valid_q <= snap_valid_d;
      end
   end

   for (genvar g = 0; g < NUM_CNT; g++) begin : g_out
      assign cnt_o[g*COUNTER_WIDTH +: COUNTER_WIDTH]  = cnt_q[g];
      assign snap_o[g*COUNTER_WIDTH +: COUNTER_WIDTH] = snap_q[g];
      assign running_o[g] = (state_q[g] == ST_RUN);
   end

   assign ovf_o        = ovf_q;
   assign snap_valid_o = snap_valid_q;

endmodule

// File: tb/tb_metrics_counter_bank.sv
// Bench for metrics_counter_bank: two instances (16-bit and 4-bit counters) share
// one stimulus stream; a channel-level model predicts both every cycle, and
// literal expectations pin the headline scenarios.
module tb_metrics_counter_bank;

   logic       clk;
   logic       rst_n;
   logic [3:0] cfg_en, cfg_clear, cfg_evt_mode, cfg_trig, cfg_sat;
   logic [3:0] event_i, start_i, stop_i;
   logic       snap_i;

   logic [63:0] w_cnt, w_snap;
   logic        w_svld;
   logic [3:0]  w_ovf, w_run;
   logic [15:0] n_cnt, n_snap;
   logic        n_svld;
   logic [3:0]  n_ovf, n_run;

   int n_tests = 0;
   int n_fail  = 0;

   metrics_counter_bank #(.NUM_CNT(4), .COUNTER_WIDTH(16)) dut_w (
      .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_clear(cfg_clear),
      .cfg_evt_mode(cfg_evt_mode), .cfg_trig(cfg_trig), .cfg_sat(cfg_sat),
      .event_i(event_i), .start_i(start_i), .stop_i(stop_i), .snap_i(snap_i),
      .cnt_o(w_cnt), .snap_o(w_snap), .snap_valid_o(w_svld), .ovf_o(w_ovf), .running_o(w_run));

   metrics_counter_bank #(.NUM_CNT(4), .COUNTER_WIDTH(4)) dut_n (
      .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_clear(cfg_clear),
      .cfg_evt_mode(cfg_evt_mode), .cfg_trig(cfg_trig), .cfg_sat(cfg_sat),
      .event_i(event_i), .start_i(start_i), .stop_i(stop_i), .snap_i(snap_i),
      .cnt_o(n_cnt), .snap_o(n_snap), .snap_valid_o(n_svld), .ovf_o(n_ovf), .running_o(n_run));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Channel life cycle as booleans: on = enabled since last disable, run = counting,
   // done = finished a triggered window. Index k: 0 = 16-bit instance, 1 = 4-bit.
   logic [63:0] m_cnt  [2][4];
   logic [63:0] m_snap [2][4];
   bit          m_ovf  [2][4];
   bit          m_on [4], m_run [4], m_done [4], m_trig [4];
   bit          m_svld;

   function automatic logic [63:0] top_val(input int k);
      return (k == 0) ? 64'hFFFF : 64'hF;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) begin
               m_cnt[k][i] = 0; m_snap[k][i] = 0; m_ovf[k][i] = 0;
            end
         for (int i = 0; i < 4; i++) begin
            m_on[i] = 0; m_run[i] = 0; m_done[i] = 0; m_trig[i] = 0;
         end
         m_svld = 0;
      end else begin
         m_svld = snap_i;
         for (int i = 0; i < 4; i++) begin
            bit counts;
            counts = m_run[i] && (cfg_evt_mode[i] ? event_i[i] : 1'b1);
            for (int k = 0; k < 2; k++) begin
               if (snap_i) m_snap[k][i] = m_cnt[k][i];
               if (cfg_clear[i]) begin
                  m_cnt[k][i] = 0; m_ovf[k][i] = 0;
               end else if (counts) begin
                  if (m_cnt[k][i] == top_val(k)) begin
                     m_ovf[k][i] = 1;
                     if (!cfg_sat[i]) m_cnt[k][i] = 0;
                  end else begin
                     m_cnt[k][i] = m_cnt[k][i] + 1;
                  end
               end
            end
            if (!cfg_en[i]) begin
               m_on[i] = 0; m_run[i] = 0; m_done[i] = 0;
            end else if (!m_on[i]) begin
               m_on[i] = 1; m_trig[i] = cfg_trig[i]; m_run[i] = !cfg_trig[i];
            end else if (m_trig[i]) begin
               if (!m_run[i] && !m_done[i]) begin
                  if (start_i[i]) m_run[i] = 1;
               end else if (m_run[i] && stop_i[i]) begin
                  m_run[i] = 0; m_done[i] = 1;
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         check($sformatf("cnt_w[%0d]", i),  64'(w_cnt[i*16 +: 16]),  m_cnt[0][i]);
         check($sformatf("cnt_n[%0d]", i),  64'(n_cnt[i*4 +: 4]),    m_cnt[1][i]);
         check($sformatf("snap_w[%0d]", i), 64'(w_snap[i*16 +: 16]), m_snap[0][i]);
         check($sformatf("snap_n[%0d]", i), 64'(n_snap[i*4 +: 4]),   m_snap[1][i]);
         check($sformatf("ovf_w[%0d]", i),  64'(w_ovf[i]), 64'(m_ovf[0][i]));
         check($sformatf("ovf_n[%0d]", i),  64'(n_ovf[i]), 64'(m_ovf[1][i]));
         check($sformatf("run_w[%0d]", i),  64'(w_run[i]), 64'(m_run[i]));
         check($sformatf("run_n[%0d]", i),  64'(n_run[i]), 64'(m_run[i]));
      end
      check("snap_valid_w", 64'(w_svld), 64'(m_svld));
      check("snap_valid_n", 64'(n_svld), 64'(m_svld));
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int rc;
      logic [19:0] evt_pat;
      rst_n = 1'b0;
      cfg_en = '0; cfg_clear = '0; cfg_evt_mode = '0; cfg_trig = '0; cfg_sat = '0;
      event_i = '0; start_i = '0; stop_i = '0; snap_i = 1'b0;
      cyc(2);
      check("reset cnt_w", w_cnt, 64'd0);
      check("reset run_w", 64'(w_run), 64'd0);
      rst_n = 1'b1;
      cyc(2);

      // 1. free-run cycle count on channel 0 for 10 enabled cycles
      rc = 0;
      cfg_en[0] = 1'b1;
      repeat (10) begin @(negedge clk); if (w_run[0]) rc++; end
      cfg_en[0] = 1'b0;
      repeat (4) begin @(negedge clk); if (w_run[0]) rc++; end
      check("t1 running cycles", 64'(rc), 64'd10);
      check("t1 cnt", 64'(w_cnt[15:0]), 64'd10);

      // 2. triggered window on channel 1: start at cycle 3, stop at cycle 9
      cfg_trig[1] = 1'b1; cfg_en[1] = 1'b1;
      cyc(3); start_i[1] = 1'b1;
      cyc(1); start_i[1] = 1'b0;
      cyc(5); stop_i[1] = 1'b1;
      cyc(1); stop_i[1] = 1'b0;
      cyc(2);
      check("t2 cnt", 64'(w_cnt[31:16]), 64'd6);
      check("t2 done not running", 64'(w_run[1]), 64'd0);
      start_i[1] = 1'b1; cyc(1); start_i[1] = 1'b0; cyc(3);
      check("t2 restart ignored", 64'(w_cnt[31:16]), 64'd6);
      cfg_trig[1] = 1'b0; cyc(3);
      check("t2 trig change while done", 64'(w_run[1]), 64'd0);
      // re-arm, then start and stop together in ARMED: start wins
      cfg_en[1] = 1'b0; cyc(1);
      cfg_trig[1] = 1'b1; cfg_en[1] = 1'b1; cyc(2);
      start_i[1] = 1'b1; stop_i[1] = 1'b1; cyc(1);
      start_i[1] = 1'b0; stop_i[1] = 1'b0;
      check("t2 start beats stop", 64'(w_run[1]), 64'd1);
      cyc(2); stop_i[1] = 1'b1; cyc(1); stop_i[1] = 1'b0; cfg_en[1] = 1'b0; cyc(1);

      // 3. event counting on channel 2: 7 pulses in 20 cycles
      evt_pat = 20'b1011_0000_1100_0100_1000;
      cfg_evt_mode[2] = 1'b1; cfg_en[2] = 1'b1;
      cyc(1);
      for (int i = 0; i < 20; i++) begin event_i[2] = evt_pat[i]; cyc(1); end
      event_i[2] = 1'b0; cfg_en[2] = 1'b0;
      cyc(2);
      check("t3 event cnt", 64'(w_cnt[47:32]), 64'd7);

      // 4. overflow on channel 3 of the 4-bit instance
      cfg_en[3] = 1'b1; cyc(17); cfg_en[3] = 1'b0; cyc(2);
      check("t4 wrap cnt", 64'(n_cnt[15:12]), 64'd1);
      check("t4 wrap ovf", 64'(n_ovf[3]), 64'd1);
      cfg_clear[3] = 1'b1; cyc(1); cfg_clear[3] = 1'b0;
      cfg_sat[3] = 1'b1; cfg_en[3] = 1'b1; cyc(17); cfg_en[3] = 1'b0; cyc(2);
      check("t4 sat cnt", 64'(n_cnt[15:12]), 64'd15);
      check("t4 sat ovf", 64'(n_ovf[3]), 64'd1);
      cfg_clear[3] = 1'b1; cyc(1); cfg_clear[3] = 1'b0;
      check("t4 clear cnt", 64'(n_cnt[15:12]), 64'd0);
      check("t4 clear ovf", 64'(n_ovf[3]), 64'd0);

      // 5. coherent snapshot with a same-cycle clear on channel 0
      cfg_en = '0; cfg_trig = '0; cfg_evt_mode = '0; cfg_sat = '0;
      cfg_clear = 4'b1111; cyc(1); cfg_clear = '0;
      cfg_en[1] = 1'b1; cyc(100);
      cfg_en[0] = 1'b1; cyc(101);
      snap_i = 1'b1; cfg_clear[0] = 1'b1; cyc(1);
      snap_i = 1'b0; cfg_clear[0] = 1'b0;
      check("t5 snap ch0", 64'(w_snap[15:0]), 64'd100);
      check("t5 snap ch1", 64'(w_snap[31:16]), 64'd200);
      check("t5 snap_valid", 64'(w_svld), 64'd1);
      check("t5 cleared cnt0", 64'(w_cnt[15:0]), 64'd0);
      cyc(1);
      check("t5 snap_valid drops", 64'(w_svld), 64'd0);
      snap_i = 1'b1; cyc(2); snap_i = 1'b0; cyc(3);

      // 6. asynchronous reset while channels 0 and 1 are running
      cfg_en = 4'b0011; cyc(5);
      #2 rst_n = 1'b0;
      #1;
      check("t6 reset cnt_w", w_cnt, 64'd0);
      check("t6 reset snap_w", w_snap, 64'd0);
      check("t6 reset run/ovf", 64'({w_run, w_ovf, w_svld}), 64'd0);
      cfg_en = '0;
      cyc(2); rst_n = 1'b1; cyc(3);
      check("t6 idle after reset", 64'(w_cnt[31:0]), 64'd0);
      cfg_en[0] = 1'b1; cyc(5);
      check("t6 restart cnt", 64'(w_cnt[15:0]), 64'd4);
      cfg_en = '0; cyc(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
